// File: rtl/fixed2float_pkg.sv
// ============================================================
// Module : fixed2float_pkg -- shared widths and float layout
// Rev    : 1.0
// ============================================================
`default_nettype none

package fixed2float_pkg;

  localparam int c_fixed_w_def = 43;
  localparam int c_exp_w_def   = 5;
  localparam int c_mant_w_def  = 10;

  typedef struct packed {
    logic                    sign;
    logic [c_exp_w_def-1:0]  exp;
    logic [c_mant_w_def-1:0] mant;
  } float_t;

endpackage

`default_nettype wire

// File: rtl/fixed2float_lead_one_det.sv
// ============================================================
// Module : lead_one_det -- index of the highest set bit
// Rev    : 1.0
// ============================================================
`default_nettype none

module lead_one_det #(
  parameter int WIDTH = 42,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_found
);

  // Ascending scan: the last hit is the most significant one.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i_vec[i]) begin
        o_idx   = IDX_W'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fixed2float_pipe.sv
// ============================================================
// Module : fixed2float_pipe -- 3-stage signed fixed to float
// Rev    : 1.0
// ============================================================
`default_nettype none

module fixed2float_pipe
  import fixed2float_pkg::*;
#(
  parameter int FIXED_W   = c_fixed_w_def,
  parameter int EXP_W     = c_exp_w_def,
  parameter int MANT_W    = c_mant_w_def,
  parameter int ROUND_RNE = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [FIXED_W-1:0]      fixed_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+MANT_W:0]   float_out,
  output logic                    ovf,
  output logic                    unf
);

  localparam int c_mag_w  = FIXED_W - 1;
  localparam int c_p_w    = (c_mag_w > 1) ? $clog2(c_mag_w) : 1;
  localparam int c_ew     = ((c_p_w > EXP_W) ? c_p_w : EXP_W) + 2;
  localparam int c_norm_w = c_mag_w + MANT_W + 2;
  localparam logic [c_ew-1:0]  c_exp_max = c_ew'((2 ** EXP_W) - 1);
  localparam logic [c_ew-1:0]  c_mant_w  = c_ew'(MANT_W);
  localparam logic [c_p_w-1:0] c_top_idx = c_p_w'(c_mag_w - 1);

  logic w_enable;
  assign w_enable  = !out_valid || out_ready;
  assign in_ready  = w_enable;

  // ---------------- S1: sign / magnitude ----------------
  logic               r_s1_valid, r_s1_sign, r_s1_maxneg;
  logic [c_mag_w-1:0] r_s1_mag;
  logic [c_mag_w-1:0] w_mag;
  logic               w_maxneg;

  assign w_mag    = fixed_in[FIXED_W-1] ? -fixed_in[c_mag_w-1:0] : fixed_in[c_mag_w-1:0];
  assign w_maxneg = fixed_in[FIXED_W-1] && (fixed_in[c_mag_w-1:0] == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_sign   <= 1'b0;
      r_s1_maxneg <= 1'b0;
      r_s1_mag    <= '0;
    end else if (w_enable) begin
      r_s1_valid  <= in_valid;
      r_s1_sign   <= fixed_in[FIXED_W-1];
      r_s1_maxneg <= w_maxneg;
      r_s1_mag    <= w_mag;
    end
  end

  // ---------------- S2: leading one + normalise ----------------
  logic [c_p_w-1:0]    w_p;
  logic                w_found;
  logic [c_ew-1:0]     w_p_ext, w_exp;
  logic [c_norm_w-2:0] w_norm;
  logic                w_small;

  lead_one_det #(
    .WIDTH (c_mag_w),
    .IDX_W (c_p_w)
  ) u_lod (
    .i_vec   (r_s1_mag),
    .o_idx   (w_p),
    .o_found (w_found)
  );

  // Leading one lands just above bit c_norm_w-2 and is dropped by the cast.
  assign w_norm  = (c_norm_w-1)'({r_s1_mag, {(MANT_W+2){1'b0}}} << (c_top_idx - w_p));
  assign w_p_ext = {{(c_ew-c_p_w){1'b0}}, w_p};
  assign w_small = !w_found || (w_p_ext < c_mant_w);
  assign w_exp   = w_p_ext - c_mant_w;

  logic              r_s2_valid, r_s2_sign, r_s2_zero, r_s2_unf, r_s2_maxneg;
  logic              r_s2_round, r_s2_sticky;
  logic [c_ew-1:0]   r_s2_exp;
  logic [MANT_W-1:0] r_s2_mant;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_valid  <= 1'b0;
      r_s2_sign   <= 1'b0;
      r_s2_zero   <= 1'b0;
      r_s2_unf    <= 1'b0;
      r_s2_maxneg <= 1'b0;
      r_s2_round  <= 1'b0;
      r_s2_sticky <= 1'b0;
      r_s2_exp    <= '0;
      r_s2_mant   <= '0;
    end else if (w_enable) begin
      r_s2_valid  <= r_s1_valid;
      r_s2_sign   <= r_s1_sign;
      r_s2_zero   <= w_small;
      r_s2_unf    <= w_found && w_small;
      r_s2_maxneg <= r_s1_maxneg;
      r_s2_exp    <= w_small ? '0 : w_exp;
      r_s2_mant   <= w_norm[c_norm_w-2 -: MANT_W];
      r_s2_round  <= w_norm[c_norm_w-2-MANT_W];
      r_s2_sticky <= |w_norm[c_norm_w-3-MANT_W:0];
    end
  end

  // ---------------- S3: round + pack ----------------
  logic              w_inc, w_carry, w_ovf;
  logic [MANT_W-1:0] w_mant_r;
  logic [c_ew-1:0]   w_exp_r;

  assign w_inc               = (ROUND_RNE != 0) && r_s2_round && (r_s2_sticky || r_s2_mant[0]);
  assign {w_carry, w_mant_r} = {1'b0, r_s2_mant} + {{MANT_W{1'b0}}, w_inc};
  assign w_exp_r             = r_s2_exp + {{(c_ew-1){1'b0}}, w_carry};
  assign w_ovf               = r_s2_maxneg || (!r_s2_zero && (w_exp_r > c_exp_max));

  logic                  r_s3_valid, r_ovf, r_unf;
  logic [EXP_W+MANT_W:0] r_float;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s3_valid <= 1'b0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
      r_float    <= '0;
    end else if (w_enable) begin
      r_s3_valid <= r_s2_valid;
      r_ovf      <= w_ovf;
      r_unf      <= r_s2_unf && !w_ovf;
      if (w_ovf)
        r_float <= {r_s2_sign, {EXP_W{1'b1}}, {MANT_W{1'b1}}};
      else if (r_s2_zero)
        r_float <= {r_s2_sign, {(EXP_W+MANT_W){1'b0}}};
      else
        r_float <= {r_s2_sign, w_exp_r[EXP_W-1:0], w_mant_r};
    end
  end

  assign out_valid = r_s3_valid;
  assign float_out = r_float;
  assign ovf       = r_ovf;
  assign unf       = r_unf;

endmodule

`default_nettype wire

// File: tb/tb_fixed2float_pipe.sv
// ============================================================
// Module : tb_fixed2float_pipe -- scoreboard bench, RNE and truncate DUTs
// Rev    : 1.0
// ============================================================
`default_nettype none

module tb_fixed2float_pipe;
  import fixed2float_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [42:0] fixed_in;
  logic        out_ready;
  logic        in_ready1, in_ready0, out_valid1, out_valid0;
  logic [15:0] f1, f0;
  logic        ovf1, unf1, ovf0, unf0;

  fixed2float_pipe #(.ROUND_RNE(1)) dut_rne (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready1),
    .fixed_in(fixed_in), .out_valid(out_valid1), .out_ready(out_ready),
    .float_out(f1), .ovf(ovf1), .unf(unf1));

  fixed2float_pipe #(.ROUND_RNE(0)) dut_trn (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready0),
    .fixed_in(fixed_in), .out_valid(out_valid0), .out_ready(out_ready),
    .float_out(f0), .ovf(ovf0), .unf(unf0));

  always #5 clk = ~clk;

  typedef struct { logic [17:0] e1; logic [17:0] e0; int cyc; bit chk_lat; } sb_t;
  typedef struct { logic [42:0] x; logic [17:0] e1; logic [17:0] e0; } vec_t;

  sb_t         q[$];
  int          n_cmp = 0, n_err = 0, n_out = 0, cyc = 0;
  int          ready_mode = 0;
  bit          acc = 0, lat_chk = 0, use_lit = 0, prev_stall = 0;
  logic [17:0] lit_e1, lit_e0, held1, held0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Independent arithmetic model: {ovf, unf, sign, exp, mant}.
  function automatic logic [17:0] model(input logic [42:0] x, input bit rne);
    logic [42:0] a;
    logic [41:0] mag;
    float_t      fl;
    int p, e, m;
    bit rb, st;
    if (x == 43'h400_0000_0000) return {2'b10, 16'hFFFF};
    a   = x[42] ? -x : x;
    mag = a[41:0];
    if (mag == 0) return {2'b00, x[42], 15'd0};
    p = 0;
    for (int i = 0; i < 42; i++) if (mag[i]) p = i;
    if (p < 10) return {2'b01, x[42], 15'd0};
    e = p - 10;
    m = int'((mag >> (p - 10)) & 42'h3FF);
    if (rne && p >= 11) begin
      rb = mag[p-11];
      st = ((mag & ((42'd1 << (p - 11)) - 42'd1)) != 0);
      if (rb && (st || m[0])) m++;
      if (m == 1024) begin m = 0; e++; end
    end
    if (e > 31) return {2'b10, x[42], 15'h7FFF};
    fl.sign = x[42];
    fl.exp  = 5'(e);
    fl.mant = 10'(m);
    return {2'b00, fl};
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (ready_mode == 1)      out_ready = ($urandom_range(0, 3) != 0);
    else if (ready_mode == 2) out_ready = 1'b0;
    else                      out_ready = 1'b1;
  end

  // Monitor/scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    sb_t e;
    if (!reset_n) begin
      prev_stall = 0;
      acc        = 0;
    end else begin
      if (prev_stall) begin
        check_eq("stall_hold_rne", {out_valid1, ovf1, unf1, f1}, {1'b1, held1});
        check_eq("stall_hold_trn", {out_valid0, ovf0, unf0, f0}, {1'b1, held0});
      end
      if (out_valid1 && out_ready) begin
        n_out++;
        if (q.size() == 0) begin
          check_eq("unexpected_out", 64'(q.size()), 64'd1);
        end else begin
          e = q.pop_front();
          check_eq("out_rne", {ovf1, unf1, f1}, e.e1);
          check_eq("out_trn", {out_valid0, ovf0, unf0, f0}, {1'b1, e.e0});
          if (e.chk_lat) check_eq("latency", 64'(cyc - e.cyc), 64'd3);
        end
      end
      if (in_valid && in_ready1) begin
        e.e1      = use_lit ? lit_e1 : model(fixed_in, 1'b1);
        e.e0      = use_lit ? lit_e0 : model(fixed_in, 1'b0);
        e.cyc     = cyc;
        e.chk_lat = lat_chk;
        q.push_back(e);
      end
      prev_stall = out_valid1 && !out_ready;
      held1      = {ovf1, unf1, f1};
      held0      = {ovf0, unf0, f0};
      acc        = in_valid && in_ready1;
    end
  end

  task automatic send(input logic [42:0] x);
    int k = 0;
    fixed_in = x;
    in_valid = 1'b1;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!acc && k < 200);
    if (!acc) check_eq("send_timeout", 64'(k), 64'd0);
  endtask

  task automatic drain();
    int k = 0;
    in_valid = 1'b0;
    while (q.size() != 0 && k < 1000) begin
      @(posedge clk);
      k++;
    end
    check_eq("drain_empty", 64'(q.size()), 64'd0);
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t        dir[$];
    logic [63:0] r;
    logic [42:0] x;
    int          outs_before;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    fixed_in  = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", {out_valid1, out_valid0}, 2'b00);
    check_eq("rst_in_ready",  {in_ready1, in_ready0}, 2'b11);
    check_eq("rst_float",     {f1, f0}, 32'h0);
    check_eq("rst_flags",     {ovf1, unf1, ovf0, unf0}, 4'h0);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;

    dir.push_back('{43'h800,            18'h00400, 18'h00400});
    dir.push_back('{43'hFFF,            18'h00800, 18'h007FF});
    dir.push_back('{43'h7FF_FFFF_F800,  18'h08400, 18'h08400});
    dir.push_back('{43'h400_0000_0000,  18'h2FFFF, 18'h2FFFF});
    dir.push_back('{43'h3FF,            18'h10000, 18'h10000});
    dir.push_back('{43'h3FF_FFFF_FFFF,  18'h27FFF, 18'h07FFF});
    dir.push_back('{43'h400,            18'h00000, 18'h00000});
    dir.push_back('{43'h7FF,            18'h003FF, 18'h003FF});
    dir.push_back('{43'h0,              18'h00000, 18'h00000});
    dir.push_back('{43'h7FF_FFFF_FFFF,  18'h18000, 18'h18000});
    dir.push_back('{43'h1801,           18'h00A00, 18'h00A00});
    dir.push_back('{43'h1802,           18'h00A00, 18'h00A00});
    dir.push_back('{43'h1806,           18'h00A02, 18'h00A01});
    dir.push_back('{43'h1803,           18'h00A01, 18'h00A00});

    use_lit = 1;
    lat_chk = 1;
    foreach (dir[i]) begin
      lit_e1 = dir[i].e1;
      lit_e0 = dir[i].e0;
      send(dir[i].x);
    end
    drain();
    use_lit = 0;
    lat_chk = 0;

    ready_mode = 1;
    for (int i = 0; i < 300; i++) begin
      r = {$urandom(), $urandom()};
      x = r[42:0] >> $urandom_range(0, 42);
      if ($urandom_range(0, 1) == 1) x = -x;
      send(x);
      if ($urandom_range(0, 7) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    drain();

    // Reset with three samples in flight and the output stalled.
    ready_mode = 0;
    send(43'h12345);
    send(43'h7FF_FFFF_0000);
    send(43'h3FF_FFFF_FFFF);
    in_valid   = 1'b0;
    ready_mode = 2;
    out_ready  = 1'b0;
    #1;
    check_eq("pre_rst_valid", out_valid1, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", {out_valid1, out_valid0}, 2'b00);
    check_eq("mid_rst_in_ready",  {in_ready1, in_ready0}, 2'b11);
    check_eq("mid_rst_float",     {ovf1, unf1, f1}, 18'h0);
    q.delete();
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    ready_mode = 0;
    outs_before = n_out;
    @(posedge clk); #1;
    send(43'h800);
    send(43'h7FF_FFFF_FFFF);
    drain();
    check_eq("post_rst_out_count", 64'(n_out - outs_before), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/fixed2float_pipe.md
FIXED2FLOAT_PIPE -- requirements
Module: fixed2float_pipe

Interface
REQ-001 Parameter FIXED_W, default 43: width of the two's-complement fixed input.
REQ-002 Parameter EXP_W, default 5: float exponent field width.
REQ-003 Parameter MANT_W, default 10: float mantissa field width, hidden one excluded.
REQ-004 Parameter ROUND_RNE, default 1: 1 selects round-to-nearest-even, 0 selects truncate.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset_n  input  1  reset, asynchronous and active-low.
REQ-007 in_valid  input  1  fixed_in holds a sample.
REQ-008 in_ready  output  1  block accepts a sample this cycle.
REQ-009 fixed_in  input  FIXED_W  signed fixed-point sample.
REQ-010 out_valid  output  1  float_out and flags hold a result.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 float_out  output  1+EXP_W+MANT_W  {sign, exp, mant}.
REQ-013 ovf  output  1  result saturated; qualified by out_valid.
REQ-014 unf  output  1  nonzero input flushed to zero; qualified by out_valid.

Function
REQ-015 A sample transfers when in_valid and in_ready are both high; a result transfers when out_valid and out_ready are both high.
REQ-016 The pipeline has three register stages: S1 sign/magnitude, S2 leading-one detect and normalise, S3 round and pack.
REQ-017 Advance enable = !out_valid || out_ready; every stage and its valid bit move only when enable is high; in_ready equals enable.
REQ-018 Latency is 3 cycles from input transfer to out_valid with out_ready held high; throughput is one sample per cycle.
REQ-019 With out_valid high and out_ready low, float_out, ovf, unf and all stage contents hold unchanged.
REQ-020 sign = fixed_in MSB; magnitude = |fixed_in| in FIXED_W-1 bits.
REQ-021 The most-negative input (MSB 1, rest 0) gives sign 1, exp all ones, mant all ones, ovf=1.
REQ-022 p = leading-one index of magnitude; exp = p-MANT_W; mant = magnitude[p-1 : p-MANT_W].
REQ-023 If p < MANT_W, or magnitude is zero, then exp=0 and mant=0 with sign preserved; unf=1 only if magnitude is nonzero.
REQ-024 ROUND_RNE=1: round bit = magnitude[p-MANT_W-1], sticky = OR of the lower bits; increment when round && (sticky || mant LSB); a mant carry increments exp.
REQ-025 If the rounded exp exceeds 2^EXP_W-1, output exp all ones, mant all ones, ovf=1.
REQ-026 ROUND_RNE=0: discarded bits are dropped and ovf is asserted only by REQ-021.
REQ-027 exp arithmetic is at least EXP_W+1 bits wide; no silent wrap is allowed.

Reset
REQ-028 reset_n low asynchronously clears all stage valid bits, float_out, ovf and unf to 0; in_ready is then 1.
REQ-029 Reset mid-stream discards in-flight samples; the first output after release comes from a sample accepted after release.

Structure
REQ-030 Package fixed2float_pkg holds the default widths and a packed float struct type {sign, exp, mant}.
REQ-031 Sub-module lead_one_det (parametrised width, combinational priority encoder giving index and found flag) sits in S2.

Verification (defaults; ROUND_RNE=1 unless stated)
REQ-032 fixed_in=0x800 -> after 3 cycles float_out=0x0400, ovf=0, unf=0.
REQ-033 fixed_in=0xFFF -> 0x0800 (tie, rounds up to even, mant carry); with ROUND_RNE=0 -> 0x07FF.
REQ-034 fixed_in=-0x800 -> 0x8400; fixed_in=0x40000000000 -> 0xFFFF with ovf=1; fixed_in=0x3FF -> 0x0000 with unf=1.
REQ-035 fixed_in=0x3FFFFFFFFFF -> 0x7FFF with ovf=1 (rounding overflow).
REQ-036 Random stream with random out_ready stalls -> outputs match a golden model in order with no drop or duplicate; outputs stable during stalls.
REQ-037 Assert reset_n low with 3 samples in flight -> out_valid=0 immediately; no stale result after release.
